// File: rtl/down_count4.sv
// down_count4: loadable down-counter / timer with valid/ready load,
// one-cycle terminal-count pulse and optional auto-reload.
// FSM: IDLE (wait for load), RUN (count down), DONE (tc cycle, one cycle).
// Optional prescaler enabled by defining DOWN_COUNT4_PRESCALE_EN; it adds
// parameter PRESCALE so that a RUN decrement needs PRESCALE enabled cycles.
module down_count4 #(
  parameter int unsigned       WIDTH          = 4,
  parameter logic [WIDTH-1:0]  RELOAD_DEFAULT = WIDTH'(4'hF)
`ifdef DOWN_COUNT4_PRESCALE_EN
  , parameter int unsigned     PRESCALE       = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] out_next;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_next;
  logic             load_accept;
  logic             tick;

  // Handshake and status outputs are decoded straight from the state register.
  assign load_ready  = (state != RUN);
  assign busy        = (state == RUN);
  assign tc          = (state == DONE);
  assign load_accept = load_valid & load_ready;

`ifdef DOWN_COUNT4_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic          presc_clr;

  // A fresh count period starts on any load accept or auto-reload into RUN.
  assign presc_clr = load_accept || ((state == DONE) && (state_next == RUN));
  assign tick      = en && (presc == PRESCALE_LAST);

  // Prescale counter: advances on enabled RUN cycles, holds when en=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (presc_clr) begin
      presc <= '0;
    end else if ((state == RUN) && en) begin
      presc <= (presc == PRESCALE_LAST) ? '0 : presc + PW'(1);
    end
  end
`else
  assign tick = en;
`endif

  // Next-state and datapath decode; a load always takes the same path
  // whether it is accepted in IDLE or in DONE.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_next  = state;
    out_next    = out;
    reload_next = reload_reg;
    unique case (state)
      IDLE: begin
        if (load_accept) begin
          reload_next = load_data;
          out_next    = load_data;
          state_next  = (load_data != '0) ? RUN : IDLE;
        end
      end
      RUN: begin
        if (tick) begin
          if (out > WIDTH'(1)) begin
            out_next = out - WIDTH'(1);
          end else begin
            // Last step lands on zero; never wraps below it.
            out_next   = '0;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (load_accept) begin
          reload_next = load_data;
          out_next    = load_data;
          state_next  = (load_data != '0) ? RUN : IDLE;
        end else if (auto_reload && (reload_reg != '0)) begin
          out_next   = reload_reg;
          state_next = RUN;
        end else begin
          out_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        out_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // State, count and reload registers with synchronous reset priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state      <= IDLE;
      out        <= '0;
      reload_reg <= RELOAD_DEFAULT;
    end else begin
      state      <= state_next;
      out        <= out_next;
      reload_reg <= reload_next;
    end
  end

endmodule

// File: tb/tb_down_count4.sv
// tb_down_count4: directed stimulus with hand-computed expectations pushed
// into a scoreboard queue; a separate monitor pops one entry per cycle and
// compares it with the registered DUT outputs on the falling edge.
module tb_down_count4;

  typedef struct packed {
    logic [3:0] out;
    logic       tc;
    logic       busy;
    logic       ready;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] load_data = 4'h0;
  logic       load_ready;
  logic       auto_reload = 1'b0;
  logic [3:0] out;
  logic       tc;
  logic       busy;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  down_count4 dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .auto_reload(auto_reload),
    .out        (out),
    .tc         (tc),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are valid every cycle; compare away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = '{out: out, tc: tc, busy: busy, ready: load_ready};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got out=%h tc=%b busy=%b ready=%b, want out=%h tc=%b busy=%b ready=%b",
                 nm, a.out, a.tc, a.busy, a.ready, e.out, e.tc, e.busy, e.ready);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input string nm, input logic rst, input logic e_n,
                      input logic lv, input logic [3:0] ld, input logic ar,
                      input logic [3:0] x_out, input logic x_tc,
                      input logic x_busy, input logic x_rdy);
    @(negedge clk);
    #1;
    reset       = rst;
    en          = e_n;
    load_valid  = lv;
    load_data   = ld;
    auto_reload = ar;
    exp_q.push_back('{out: x_out, tc: x_tc, busy: x_busy, ready: x_rdy});
    name_q.push_back(nm);
    @(posedge clk);
  endtask

  initial begin
    // reset state
    step("reset",      1, 0, 0, 4'h0, 0, 4'h0, 0, 0, 1);
    // 1: load 5, count to zero, single tc, back to IDLE
    step("t1_load5",   0, 1, 1, 4'h5, 0, 4'h5, 0, 1, 0);
    step("t1_4",       0, 1, 0, 4'h0, 0, 4'h4, 0, 1, 0);
    step("t1_3",       0, 1, 0, 4'h0, 0, 4'h3, 0, 1, 0);
    step("t1_2",       0, 1, 0, 4'h0, 0, 4'h2, 0, 1, 0);
    step("t1_1",       0, 1, 0, 4'h0, 0, 4'h1, 0, 1, 0);
    step("t1_tc",      0, 1, 0, 4'h0, 0, 4'h0, 1, 0, 1);
    step("t1_idle",    0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 1);
    step("t1_idle2",   0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 1);
    // 2: auto-reload with load 3 -> period 4
    step("t2_load3",   0, 1, 1, 4'h3, 1, 4'h3, 0, 1, 0);
    step("t2_2",       0, 1, 0, 4'h0, 1, 4'h2, 0, 1, 0);
    step("t2_1",       0, 1, 0, 4'h0, 1, 4'h1, 0, 1, 0);
    step("t2_tc1",     0, 1, 0, 4'h0, 1, 4'h0, 1, 0, 1);
    step("t2_rel3",    0, 1, 0, 4'h0, 1, 4'h3, 0, 1, 0);
    step("t2_2b",      0, 1, 0, 4'h0, 1, 4'h2, 0, 1, 0);
    step("t2_1b",      0, 1, 0, 4'h0, 1, 4'h1, 0, 1, 0);
    step("t2_tc2",     0, 1, 0, 4'h0, 1, 4'h0, 1, 0, 1);
    step("t2_stop",    0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 1);
    // 3: load 4 with en pattern 1,0,0,1,1,1
    step("t3_load4",   0, 1, 1, 4'h4, 0, 4'h4, 0, 1, 0);
    step("t3_e1",      0, 1, 0, 4'h0, 0, 4'h3, 0, 1, 0);
    step("t3_e0a",     0, 0, 0, 4'h0, 0, 4'h3, 0, 1, 0);
    step("t3_e0b",     0, 0, 0, 4'h0, 0, 4'h3, 0, 1, 0);
    step("t3_e1b",     0, 1, 0, 4'h0, 0, 4'h2, 0, 1, 0);
    step("t3_e1c",     0, 1, 0, 4'h0, 0, 4'h1, 0, 1, 0);
    step("t3_tc",      0, 1, 0, 4'h0, 0, 4'h0, 1, 0, 1);
    step("t3_idle",    0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 1);
    // 4: load during RUN is ignored (and does not touch the reload value)
    step("t4_load6",   0, 1, 1, 4'h6, 0, 4'h6, 0, 1, 0);
    step("t4_5",       0, 1, 0, 4'h0, 0, 4'h5, 0, 1, 0);
    step("t4_4",       0, 1, 0, 4'h0, 0, 4'h4, 0, 1, 0);
    step("t4_3",       0, 1, 0, 4'h0, 0, 4'h3, 0, 1, 0);
    step("t4_ign9",    0, 1, 1, 4'h9, 0, 4'h2, 0, 1, 0);
    step("t4_1",       0, 1, 1, 4'h9, 0, 4'h1, 0, 1, 0);
    step("t4_tc",      0, 1, 0, 4'h0, 0, 4'h0, 1, 0, 1);
    step("t4_rel6",    0, 1, 0, 4'h0, 1, 4'h6, 0, 1, 0);
    // 5: reset at out=6 (with a competing load) -> reset values
    step("t5_reset",   1, 1, 1, 4'h9, 1, 4'h0, 0, 0, 1);
    step("t5_idle1",   0, 1, 0, 4'h0, 1, 4'h0, 0, 0, 1);
    step("t5_idle2",   0, 1, 0, 4'h0, 1, 4'h0, 0, 0, 1);
    step("t5_idle3",   0, 1, 0, 4'h0, 1, 4'h0, 0, 0, 1);
    // 6a: load 0 -> stays IDLE, no tc
    step("t6_load0",   0, 1, 1, 4'h0, 1, 4'h0, 0, 0, 1);
    step("t6_load0b",  0, 1, 0, 4'h0, 1, 4'h0, 0, 0, 1);
    // 6b: load in DONE beats auto-reload
    step("t6_load3",   0, 1, 1, 4'h3, 1, 4'h3, 0, 1, 0);
    step("t6_2",       0, 1, 0, 4'h0, 1, 4'h2, 0, 1, 0);
    step("t6_1",       0, 1, 0, 4'h0, 1, 4'h1, 0, 1, 0);
    step("t6_tc",      0, 1, 0, 4'h0, 1, 4'h0, 1, 0, 1);
    step("t6_ldwin2",  0, 1, 1, 4'h2, 1, 4'h2, 0, 1, 0);
    step("t6_1b",      0, 1, 0, 4'h0, 1, 4'h1, 0, 1, 0);
    step("t6_tc2",     0, 1, 0, 4'h0, 1, 4'h0, 1, 0, 1);
    // load 0 in DONE with auto_reload set: load path wins -> IDLE
    step("t6_done_l0", 0, 1, 1, 4'h0, 1, 4'h0, 0, 0, 1);
    step("t6_done_l0b",0, 1, 0, 4'h0, 1, 4'h0, 0, 0, 1);
    // all-ones load, en=0 hold
    step("t7_loadF",   0, 0, 1, 4'hF, 0, 4'hF, 0, 1, 0);
    step("t7_holdF",   0, 0, 0, 4'h0, 0, 4'hF, 0, 1, 0);
    step("t7_E",       0, 1, 0, 4'h0, 0, 4'hE, 0, 1, 0);
    // reset while RUN at 0xE, then load 1: no wrap after zero
    step("t7_reset",   1, 1, 0, 4'h0, 0, 4'h0, 0, 0, 1);
    step("t8_load1",   0, 1, 1, 4'h1, 0, 4'h1, 0, 1, 0);
    step("t8_tc",      0, 1, 0, 4'h0, 0, 4'h0, 1, 0, 1);
    step("t8_idle",    0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 1);
    step("t8_nowrap",  0, 1, 0, 4'h0, 0, 4'h0, 0, 0, 1);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/down_count4.md
Name: down_count4

Overview:
- Loadable down-counter/timer. It is the counting-down counterpart of the team's free-running 4-bit up-counter.
- Software or an upstream block loads a start value through a valid/ready handshake. The block counts down to zero on enabled cycles and emits a one-cycle terminal-count pulse.
- Optional auto-reload from the last loaded value, for periodic ticks.
- Used as a programmable delay or tick generator next to the up-counter in the training designs.

Parameters:
- WIDTH, 4, width of count, load data and reload register.
- RELOAD_DEFAULT, 4'hF, reload register value after reset.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high reset; sampled on posedge clk; overrides all other inputs
- en  input  1  count enable; decrement only on cycles with en=1
- load_valid  input  1  load request
- load_data  input  WIDTH  start value
- load_ready  output  1  block can accept a load this cycle
- auto_reload  input  1  reload from reload register on terminal count
- out  output  WIDTH  current count (registered)
- tc  output  1  terminal-count pulse (registered, 1 cycle)
- busy  output  1  high while in RUN

Behaviour:
- Reset values: state=IDLE, out=0, tc=0, busy=0, load_ready=1, reload_reg=RELOAD_DEFAULT.
- The FSM has three states: IDLE, RUN, DONE. All outputs are registered or decoded from the state register. load_ready=1 in IDLE and DONE, 0 in RUN. busy=1 only in RUN. tc=1 only in DONE.
- Load accept = load_valid & load_ready at posedge.
  - On accept: reload_reg<=load_data and out<=load_data.
  - Next state is RUN if load_data!=0.
  - If load_data==0, next state is IDLE; out=0 and no tc.
- IDLE:
  - Accepted nonzero load -> RUN.
  - Otherwise hold, out unchanged.
- RUN:
  - en=0: hold out and state.
  - en=1 and out>1: out<=out-1.
  - en=1 and out==1: out<=0, state<=DONE, so tc is high in the cycle where out==0.
  - load_valid is ignored (load_ready=0) and not queued.
- DONE (exactly one cycle), priority order:
  - Accepted load: takes the normal load path.
  - Else if auto_reload=1 and reload_reg!=0: out<=reload_reg, go to RUN.
  - Else: go to IDLE, out stays 0.
- Timing:
  - Load accepted at edge N with en held high: out=L after edge N, reaches 0 with tc=1 after edge N+L.
  - With auto_reload the period is L+1 cycles per tc; the DONE cycle does not decrement.
- Never wraps: out never transitions 0 -> max. No decrement occurs in IDLE or DONE.
- Reset mid-operation returns everything to reset values in the next cycle. No pending tc is emitted, and any pending load is dropped.
- Arithmetic is unsigned WIDTH-bit; a load of all-ones is legal.

Optional Feature:
- Macro: DOWN_COUNT4_PRESCALE_EN.
- When defined:
  - Adds parameter PRESCALE (default 4, >=1) and an internal prescale counter of width clog2(PRESCALE).
  - In RUN, a decrement happens only on every PRESCALE-th cycle with en=1.
  - The prescaler clears on reset, on load accept, and on entry to RUN via auto-reload.
  - Holds when en=0.
  - tc timing: out reaches 0 after L*PRESCALE enabled cycles.
- When undefined: no prescaler logic, decrement on every enabled RUN cycle; behaviour is as in the main Behaviour section.

Test Plan:
1. reset; load 5 with en=1 held and auto_reload=0 -> out 5,4,3,2,1,0. tc=1 exactly once, in the out=0 cycle. Then IDLE with busy=0 and load_ready=1.
2. auto_reload=1, load 3, en=1 -> out 3,2,1,0,3,2,1,0,...; tc every 4 cycles; busy=0 only in the tc cycles.
3. Load 4, with en pattern 1,0,0,1,1,1 -> out 4,3,3,3,2,1,0. tc in the cycle after the 4th enabled cycle.
4. load_valid=1 with data 9 while RUN at out=3 -> load_ready=0, no effect; out continues 2,1,0.
5. reset asserted at out=6 -> next cycle out=0, tc=0, busy=0, load_ready=1. Then with auto_reload=1 and no load, the block stays IDLE.
6. Edge loads:
   - Load 0 -> out=0, IDLE, no tc.
   - In the DONE cycle with auto_reload=1 and reload_reg=3, load 2 -> load wins, out=2, and the next tc occurs 2 cycles later.
